// File: rtl/mem_stage.sv
// MEM stage of the cotm32 pipeline: issues one valid/ready data-bus transaction
// per load/store, stalls upstream while it is outstanding, and aligns load data.
module mem_stage #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic            i_flush,
  input  logic            i_mem_read,
  input  logic            i_mem_write,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_wdata,
  output logic            o_req_valid,
  input  logic            i_req_ready,
  output logic            o_req_we,
  output logic [XLEN-1:0] o_req_addr,
  output logic [3:0]      o_req_be,
  output logic [XLEN-1:0] o_req_wdata,
  input  logic            i_rsp_valid,
  input  logic [XLEN-1:0] i_rsp_rdata,
  input  logic            i_rsp_err,
  output logic            o_stall,
  output logic            o_valid,
  output logic [XLEN-1:0] o_load_data,
  output logic            o_misaligned,
  output logic            o_bus_err
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [2:0]       funct3_q;
  logic [1:0]       off_q;
  logic             discard_q;
  logic             err_q;
  logic [XLEN-1:0]  data_q;

  logic             mem;
  logic             is_byte;
  logic             is_half;
  logic             misaligned;
  logic             start;
  logic [3:0]       be;
  logic [XLEN-1:0]  wdata_lane;
  logic [XLEN-1:0]  rsp_shift;
  logic [XLEN-1:0]  rsp_ext;

  // Request decode; reserved funct3 encodings fall through to word access.
  always_comb begin
    mem        = i_valid & (i_mem_read | i_mem_write);
    is_byte    = (i_funct3[1:0] == 2'b00);
    is_half    = (i_funct3[1:0] == 2'b01);
    misaligned = is_half ? i_addr[0] : (!is_byte && (i_addr[1:0] != 2'b00));
    start      = mem & !misaligned & !i_flush;
    if (is_byte) begin
      be         = 4'b0001 << i_addr[1:0];
      wdata_lane = {4{i_wdata[7:0]}};
    end else if (is_half) begin
      be         = i_addr[1] ? 4'b1100 : 4'b0011;
      wdata_lane = {2{i_wdata[15:0]}};
    end else begin
      be         = 4'b1111;
      wdata_lane = i_wdata;
    end
  end

  // Load alignment and sign/zero extension of the returned word.
  always_comb begin
    rsp_shift = i_rsp_rdata >> {off_q, 3'b000};
    case (funct3_q[1:0])
      2'b00:   rsp_ext = {{24{rsp_shift[7] & ~funct3_q[2]}}, rsp_shift[7:0]};
      2'b01:   rsp_ext = {{16{rsp_shift[15] & ~funct3_q[2]}}, rsp_shift[15:0]};
      default: rsp_ext = rsp_shift;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      o_req_valid <= 1'b0;
      o_req_we    <= 1'b0;
      o_req_addr  <= '0;
      o_req_be    <= '0;
      o_req_wdata <= '0;
      funct3_q    <= '0;
      off_q       <= '0;
      wait_cnt    <= '0;
      discard_q   <= 1'b0;
      err_q       <= 1'b0;
      data_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state       <= REQ;
            o_req_valid <= 1'b1;
            o_req_we    <= i_mem_write;
            o_req_addr  <= {i_addr[XLEN-1:2], 2'b00};
            o_req_be    <= be;
            o_req_wdata <= wdata_lane;
            funct3_q    <= i_funct3;
            off_q       <= i_addr[1:0];
            discard_q   <= 1'b0;
            err_q       <= 1'b0;
            data_q      <= '0;
          end
        end
        REQ: begin
          if (i_req_ready) begin
            state       <= WAIT;
            o_req_valid <= 1'b0;
            wait_cnt    <= '0;
            discard_q   <= i_flush;
          end else if (i_flush) begin
            state       <= IDLE;
            o_req_valid <= 1'b0;
          end
        end
        WAIT: begin
          // The bus cannot cancel, so a flush only marks the result for discard.
          if (i_flush) discard_q <= 1'b1;
          if (i_rsp_valid) begin
            state  <= DONE;
            err_q  <= i_rsp_err;
            data_q <= (o_req_we | i_rsp_err) ? '0 : rsp_ext;
          end else if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
            state <= DONE;
            err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stall/result outputs; IDLE decisions are made on the live EX/MEM entry.
  always_comb begin
    o_stall      = 1'b0;
    o_valid      = 1'b0;
    o_misaligned = 1'b0;
    o_load_data  = '0;
    o_bus_err    = 1'b0;
    case (state)
      IDLE: begin
        o_stall      = start;
        o_valid      = i_valid & !i_flush & !start;
        o_misaligned = mem & misaligned & !i_flush;
      end
      REQ, WAIT: o_stall = 1'b1;
      DONE: begin
        if (!discard_q && !i_flush) begin
          o_valid     = 1'b1;
          o_load_data = data_q;
          o_bus_err   = err_q;
        end
      end
      default: o_stall = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: transaction-level driver/model with a
// per-cycle compare process, directed scenarios and randomized traffic.
module tb_mem_stage;

  localparam int unsigned MAXW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_flush, i_mem_read, i_mem_write;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr, i_wdata;
  logic        o_req_valid, i_req_ready, o_req_we;
  logic [31:0] o_req_addr, o_req_wdata;
  logic [3:0]  o_req_be;
  logic        i_rsp_valid, i_rsp_err;
  logic [31:0] i_rsp_rdata;
  logic        o_stall, o_valid, o_misaligned, o_bus_err;
  logic [31:0] o_load_data;

  mem_stage #(.XLEN(32), .MAX_WAIT(MAXW)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .i_flush(i_flush),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_funct3(i_funct3),
    .i_addr(i_addr), .i_wdata(i_wdata), .o_req_valid(o_req_valid),
    .i_req_ready(i_req_ready), .o_req_we(o_req_we), .o_req_addr(o_req_addr),
    .o_req_be(o_req_be), .o_req_wdata(o_req_wdata), .i_rsp_valid(i_rsp_valid),
    .i_rsp_rdata(i_rsp_rdata), .i_rsp_err(i_rsp_err), .o_stall(o_stall),
    .o_valid(o_valid), .o_load_data(o_load_data), .o_misaligned(o_misaligned),
    .o_bus_err(o_bus_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic        exp_req_valid, exp_req_we, exp_stall, exp_valid, exp_mis, exp_err;
  logic [31:0] exp_req_addr, exp_req_wdata, exp_load;
  logic [3:0]  exp_req_be;

  int          n_stall = 0, n_valid = 0, n_req = 0, n_mis = 0;
  logic [31:0] last_addr, last_wd, last_load;
  logic [3:0]  last_be;
  logic        last_we, last_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit misal(input logic [2:0] f3, input logic [31:0] a);
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      default: return a[1:0] != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] be_of(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wd_of(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
      2'b01:   return {wd[15:0], wd[15:0]};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] ext(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[int'(off)*8 +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  task automatic clear_exp();
    exp_req_valid = 0; exp_req_we = 0; exp_req_addr = 0; exp_req_be = 0; exp_req_wdata = 0;
    exp_stall = 0; exp_valid = 0; exp_mis = 0; exp_err = 0; exp_load = 0;
  endtask

  task automatic noise();
    i_req_ready = 1'($urandom_range(0, 1));
    i_rsp_valid = 1'($urandom_range(0, 1));
    i_rsp_rdata = $urandom;
    i_rsp_err   = 1'($urandom_range(0, 1));
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  // Every-cycle comparison of all outputs against the model's expectation.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_valid", 32'(o_req_valid), 32'(exp_req_valid));
      if (exp_req_valid) begin
        chk("req_we", 32'(o_req_we), 32'(exp_req_we));
        chk("req_addr", o_req_addr, exp_req_addr);
        chk("req_be", 32'(o_req_be), 32'(exp_req_be));
        chk("req_wdata", o_req_wdata, exp_req_wdata);
      end
      chk("stall", 32'(o_stall), 32'(exp_stall));
      chk("valid", 32'(o_valid), 32'(exp_valid));
      chk("load_data", o_load_data, exp_load);
      chk("misaligned", 32'(o_misaligned), 32'(exp_mis));
      chk("bus_err", 32'(o_bus_err), 32'(exp_err));
      if (o_stall) n_stall++;
      if (o_misaligned) n_mis++;
      if (o_valid) begin n_valid++; last_load = o_load_data; last_err = o_bus_err; end
      if (o_req_valid) begin
        n_req++; last_addr = o_req_addr; last_wd = o_req_wdata; last_be = o_req_be; last_we = o_req_we;
      end
    end
  end

  // One EX/MEM instruction from presentation to retirement.
  // fmode: 0 none, 1 flush in IDLE, 2 flush at REQ cycle fidx, 3 flush at WAIT
  // cycle fidx, 4 flush in DONE, 5 reset at WAIT cycle fidx.
  task automatic run_op(input bit v, input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdata,
                        input int rdy_dly, input int rsp_lat, input bit rerr,
                        input int fmode, input int fidx);
    bit mem, disc, err, fl;
    mem  = v & (rd | wr);
    disc = 0;
    err  = 0;
    @(posedge clk); #1;
    i_valid = v; i_mem_read = rd; i_mem_write = wr; i_funct3 = f3; i_addr = a; i_wdata = wd;
    i_flush = (fmode == 1);
    noise();
    clear_exp();
    if (i_flush || !mem || misal(f3, a)) begin
      exp_valid = v & !i_flush;
      exp_mis   = mem & misal(f3, a) & !i_flush;
      return;
    end
    exp_stall = 1;
    for (int k = 0; k <= rdy_dly; k++) begin
      @(posedge clk); #1;
      fl = (fmode == 2 && fidx == k);
      i_flush = fl;
      noise();
      i_req_ready = (k == rdy_dly);
      clear_exp();
      exp_stall = 1; exp_req_valid = 1; exp_req_we = wr;
      exp_req_addr = {a[31:2], 2'b00}; exp_req_be = be_of(f3, a[1:0]); exp_req_wdata = wd_of(f3, wd);
      if (fl && k < rdy_dly) return;
      if (fl) disc = 1;
    end
    for (int j = 1; j <= int'(MAXW); j++) begin
      @(posedge clk); #1;
      i_req_ready = 1'($urandom_range(0, 1));
      i_flush = (fmode == 3 && fidx == j);
      if (i_flush) disc = 1;
      clear_exp();
      exp_stall = 1;
      if (j == rsp_lat) begin
        i_rsp_valid = 1; i_rsp_rdata = rdata; i_rsp_err = rerr;
      end else begin
        i_rsp_valid = 0; i_rsp_rdata = $urandom; i_rsp_err = 1'($urandom_range(0, 1));
      end
      if (fmode == 5 && fidx == j) begin
        rst = 1;
        @(posedge clk); #1;
        rst = 0; i_valid = 0; i_mem_read = 0; i_mem_write = 0; i_flush = 0;
        i_rsp_valid = 1; i_rsp_rdata = $urandom; i_rsp_err = 1;
        clear_exp();
        return;
      end
      if (j == rsp_lat) begin err = rerr; break; end
      if (j == int'(MAXW)) err = 1;
    end
    @(posedge clk); #1;
    fl = (fmode == 4);
    i_flush = fl;
    noise();
    clear_exp();
    exp_valid = !disc & !fl;
    exp_err   = err & exp_valid;
    exp_load  = (exp_valid && !wr && !err) ? ext(f3, a[1:0], rdata) : 32'h0;
  endtask

  initial begin
    int s, v0, r0, m0;
    bit v, rd, wr;
    logic [2:0] f3;
    logic [31:0] a;
    int fm, fi, kind;

    rst = 1; i_valid = 0; i_flush = 0; i_mem_read = 0; i_mem_write = 0; i_funct3 = 0;
    i_addr = 0; i_wdata = 0; i_req_ready = 0; i_rsp_valid = 0; i_rsp_rdata = 0; i_rsp_err = 0;
    clear_exp();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk_en = 1;
    settle();
    chk("rst_req_valid", 32'(o_req_valid), 32'h0);
    chk("rst_req_addr", o_req_addr, 32'h0);
    chk("rst_req_be", 32'(o_req_be), 32'h0);
    chk("rst_load", o_load_data, 32'h0);

    // Aligned LW, handshake immediately, response one cycle later.
    s = n_stall; v0 = n_valid;
    run_op(1, 1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1, 0, 0, 0);
    settle();
    chk("lw_stall_cycles", 32'(n_stall - s), 32'd3);
    chk("lw_valid_count", 32'(n_valid - v0), 32'd1);
    chk("lw_data", last_load, 32'hDEADBEEF);
    chk("lw_be", 32'(last_be), 32'hF);

    run_op(1, 1, 0, 3'b000, 32'h103, 32'h0, 32'h80123456, 1, 2, 0, 0, 0);
    settle();
    chk("lb_be", 32'(last_be), 32'h8);
    chk("lb_data", last_load, 32'hFFFFFF80);
    run_op(1, 1, 0, 3'b100, 32'h103, 32'h0, 32'h80123456, 0, 1, 0, 0, 0);
    settle();
    chk("lbu_data", last_load, 32'h00000080);

    run_op(1, 0, 1, 3'b001, 32'h102, 32'h0000ABCD, 32'h55555555, 0, 1, 0, 0, 0);
    settle();
    chk("sh_we", 32'(last_we), 32'h1);
    chk("sh_be", 32'(last_be), 32'hC);
    chk("sh_wdata", last_wd, 32'hABCDABCD);
    chk("sh_addr", last_addr, 32'h100);
    chk("sh_load", last_load, 32'h0);

    s = n_stall; r0 = n_req; m0 = n_mis; v0 = n_valid;
    run_op(1, 1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 1, 0, 0, 0);
    settle();
    chk("mis_count", 32'(n_mis - m0), 32'd1);
    chk("mis_valid", 32'(n_valid - v0), 32'd1);
    chk("mis_no_req", 32'(n_req - r0), 32'd0);
    chk("mis_no_stall", 32'(n_stall - s), 32'd0);

    // Flush while the request is still waiting for ready.
    r0 = n_req; v0 = n_valid;
    run_op(1, 1, 0, 3'b010, 32'h200, 32'h0, 32'h1, 8, 1, 0, 2, 4);
    run_op(0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 0, 1, 0, 0, 0);
    settle();
    chk("flush_req_cycles", 32'(n_req - r0), 32'd5);
    chk("flush_req_no_valid", 32'(n_valid - v0), 32'd0);

    v0 = n_valid;
    run_op(1, 1, 0, 3'b010, 32'h204, 32'h0, 32'h12345678, 0, 3, 0, 3, 1);
    settle();
    chk("flush_wait_no_valid", 32'(n_valid - v0), 32'd0);

    // Timeout: no response within MAX_WAIT cycles.
    s = n_stall; v0 = n_valid;
    run_op(1, 1, 0, 3'b010, 32'h300, 32'h0, 32'h0, 0, 99, 0, 0, 0);
    settle();
    chk("timeout_stall", 32'(n_stall - s), 32'd6);
    chk("timeout_valid", 32'(n_valid - v0), 32'd1);
    chk("timeout_err", 32'(last_err), 32'h1);
    chk("timeout_load", last_load, 32'h0);

    run_op(1, 1, 0, 3'b010, 32'h400, 32'h0, 32'h0, 0, 99, 0, 5, 2);
    settle();
    chk("rst_wait_req_valid", 32'(o_req_valid), 32'h0);
    chk("rst_wait_req_we", 32'(o_req_we), 32'h0);
    chk("rst_wait_req_addr", o_req_addr, 32'h0);
    chk("rst_wait_req_wdata", o_req_wdata, 32'h0);
    chk("rst_wait_stall", 32'(o_stall), 32'h0);

    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 2);
      v  = ($urandom_range(0, 7) != 0);
      rd = (kind == 1);
      wr = (kind == 2);
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 2) != 0) begin
        if (f3[1:0] == 2'b01) a[0] = 1'b0;
        else if (f3[1:0] != 2'b00) a[1:0] = 2'b00;
      end
      fm = $urandom_range(0, 11);
      if (fm > 5) fm = 0;
      fi = (fm == 2) ? $urandom_range(0, 3) : $urandom_range(1, int'(MAXW));
      run_op(v, rd, wr, f3, a, $urandom, $urandom, $urandom_range(0, 3),
             $urandom_range(1, int'(MAXW) + 2), ($urandom_range(0, 7) == 0), fm, fi);
    end
    settle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
